scope_playback: RTL and testbench

Read-out companion to the scope capture shift register. On a start request it snapshots the packed capture word (3-bit samples, newest in the least significant bits) and streams the samples out one per handshake, oldest first, with an index and an end-of-frame pulse. It sits between the capture register and any consumer (display driver, UART formatter, LED stepper) that drains samples at its own pace via valid/ready.

---
 rtl/scope_playback.sv | 124 ++++++++++++
 tb/tb_scope_playback.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/scope_playback.sv
// scope_playback: snapshots a packed 3-bit-sample capture word on a start request
// and streams the samples out oldest first over a valid/ready handshake, with a
// running index and a one-cycle done pulse after the last accepted sample.
module scope_playback #(
   parameter int scope_bits = 16,
   parameter int idx_bits   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,          // synchronous, active-low
   input  logic [scope_bits-1:0] i_captured_data,
   input  logic                  i_start,
   input  logic                  i_sample_ready,
   output logic [2:0]            o_sample_out,
   output logic                  o_sample_valid,
   output logic [idx_bits-1:0]   o_sample_index,
   output logic                  o_busy,
   output logic                  o_done
);

   // One sample is always three bits wide; the remainder of the capture word
   // above the last whole sample is padding and never reaches an output.
   localparam int sample_bits = 3;
   localparam int num_samples = scope_bits / sample_bits;
   localparam int payload     = num_samples * sample_bits;

   localparam logic [idx_bits-1:0] last_idx = idx_bits'(num_samples - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [payload-1:0]    r_shadow;
   logic [payload-1:0]    w_shadow_next;
   logic [idx_bits-1:0]   r_index;
   logic [idx_bits-1:0]   w_index_next;
   logic [2:0]            r_sample_out;
   logic                  r_valid;
   logic                  r_busy;
   logic                  r_done;

   // Padding bits are deliberately ignored; fold them into a sink so the
   // intent is visible rather than leaving a dangling input slice.
   generate
      if (scope_bits > payload) begin : g_pad
         logic w_unused_pad;
         assign w_unused_pad = ^i_captured_data[scope_bits-1:payload];
      end
   endgenerate

   // Next-state logic: load on start, shift on each accepted sample, finish after the newest.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      w_next_state  = r_state;
      w_shadow_next = r_shadow;
      w_index_next  = r_index;

      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_next_state  = SEND;
               w_shadow_next = i_captured_data[payload-1:0];
               w_index_next  = '0;
            end
         end

         SEND: begin
            // A transfer happens only here, since sample_valid is high exactly in SEND.
            if (i_sample_ready) begin
               if (r_index == last_idx) begin
                  w_next_state = DONE;
               end else begin
                  // Oldest sample sits in the top bits; shift the next one up.
                  w_shadow_next = r_shadow << sample_bits;
                  w_index_next  = r_index + 1'b1;
               end
            end
         end

         DONE: begin
            // Start is ignored here; IDLE samples it on the following edge.
            w_next_state = IDLE;
         end

         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // State, shadow and registered outputs, all updated on the rising edge.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!i_reset) begin
         r_state      <= IDLE;
         r_shadow     <= '0;
         r_index      <= '0;
         r_sample_out <= '0;
         r_valid      <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_shadow     <= w_shadow_next;
         r_index      <= w_index_next;
         r_sample_out <= (w_next_state == SEND) ? w_shadow_next[payload-1 -: sample_bits] : 3'd0;
         r_valid      <= (w_next_state == SEND);
         r_busy       <= (w_next_state != IDLE);
         r_done       <= (w_next_state == DONE);
      end
   end

   assign o_sample_out   = r_sample_out;
   assign o_sample_valid = r_valid;
   assign o_sample_index = r_index;
   assign o_busy         = r_busy;
   assign o_done         = r_done;

endmodule

// File: tb/tb_scope_playback.sv
// Directed bench for scope_playback at default parameters (16-bit word, 5 samples).
module tb_scope_playback;

   logic        clk;
   logic        reset;
   logic [15:0] captured_data;
   logic        start;
   logic        sample_ready;
   logic [2:0]  sample_out;
   logic        sample_valid;
   logic [3:0]  sample_index;
   logic        busy;
   logic        done;

   int n_cmp  = 0;
   int n_fail = 0;

   scope_playback #(
      .scope_bits (16),
      .idx_bits   (4)
   ) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_captured_data (captured_data),
      .i_start         (start),
      .i_sample_ready  (sample_ready),
      .o_sample_out    (sample_out),
      .o_sample_valid  (sample_valid),
      .o_sample_index  (sample_index),
      .o_busy          (busy),
      .o_done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle; inputs driven after this apply to the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 32'(sample_valid), 32'd0);
      check({tag, "_busy"},  32'(busy),         32'd0);
      check({tag, "_done"},  32'(done),         32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check_idle(tag);
      check({tag, "_out"}, 32'(sample_out),   32'd0);
      check({tag, "_idx"}, 32'(sample_index), 32'd0);
   endtask

   task automatic check_sample(input string tag, input int k, input logic [2:0] exp_out);
      check($sformatf("%s_valid%0d", tag, k), 32'(sample_valid), 32'd1);
      check($sformatf("%s_busy%0d",  tag, k), 32'(busy),         32'd1);
      check($sformatf("%s_done%0d",  tag, k), 32'(done),         32'd0);
      check($sformatf("%s_out%0d",   tag, k), 32'(sample_out),   32'(exp_out));
      check($sformatf("%s_idx%0d",   tag, k), 32'(sample_index), 32'(k));
   endtask

   // Called just after the start edge with sample_ready held high; samples is oldest-first, top bits first.
   task automatic drain_frame(input string tag, input logic [14:0] samples);
      logic [14:0] s;
      s = samples;
      for (int k = 0; k < 5; k++) begin
         check_sample(tag, k, s[14 - 3*k -: 3]);
         tick();
      end
      check({tag, "_dvalid"}, 32'(sample_valid), 32'd0);
      check({tag, "_dbusy"},  32'(busy),         32'd1);
      check({tag, "_ddone"},  32'(done),         32'd1);
      tick();
      check_idle({tag, "_end"});
   endtask

   initial begin
      int accepted;
      int guard;
      logic was_ready;

      reset         = 1'b0;
      start         = 1'b0;
      sample_ready  = 1'b0;
      captured_data = 16'h0000;

      // Power-up reset.
      tick();
      tick();
      check_reset_vals("por");

      // Start and reset at the same edge: reset wins.
      start         = 1'b1;
      captured_data = 16'h1234;
      tick();
      check_reset_vals("rst_start");
      start = 1'b0;
      reset = 1'b1;
      tick();
      check_reset_vals("rst_release");

      // Basic frame: 0x1234 -> 1,1,0,6,4.
      captured_data = 16'h1234;
      start         = 1'b1;
      sample_ready  = 1'b1;
      tick();
      start = 1'b0;
      drain_frame("basic", {3'd1, 3'd1, 3'd0, 3'd6, 3'd4});

      // Backpressure: ready pattern 1,0,0 repeating, five samples of 7.
      captured_data = 16'h7FFF;
      start         = 1'b1;
      sample_ready  = 1'b0;
      tick();
      start = 1'b0;
      check_sample("bp_first", 0, 3'd7);
      accepted = 0;
      guard    = 0;
      while (accepted < 5 && guard < 40) begin
         was_ready    = ((guard % 3) == 0);
         sample_ready = was_ready;
         tick();
         guard++;
         if (was_ready) accepted++;
         if (accepted < 5) begin
            check_sample("bp", accepted, 3'd7);
         end else begin
            check("bp_done_valid", 32'(sample_valid), 32'd0);
            check("bp_done",       32'(done),         32'd1);
         end
      end
      check("bp_accepted", 32'(accepted), 32'd5);
      sample_ready = 1'b1;
      tick();
      check_idle("bp_end");

      // Padding bit set, then the word changes after the load: still five zeros.
      captured_data = 16'h8000;
      start         = 1'b1;
      sample_ready  = 1'b1;
      tick();
      start         = 1'b0;
      captured_data = 16'hFFFF;
      drain_frame("pad", 15'h0000);

      // Start held through the whole frame: one frame, then a gap cycle in IDLE.
      captured_data = 16'h1234;
      start         = 1'b1;
      sample_ready  = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         check_sample("hold", k, (k == 0) ? 3'd1 : (k == 1) ? 3'd1 : (k == 2) ? 3'd0 : (k == 3) ? 3'd6 : 3'd4);
         tick();
      end
      check("hold_done",  32'(done),         32'd1);
      check("hold_dvld",  32'(sample_valid), 32'd0);
      tick();
      check_idle("hold_gap");
      tick();
      start = 1'b0;
      drain_frame("hold2", {3'd1, 3'd1, 3'd0, 3'd6, 3'd4});

      // Reset after the second transfer: frame discarded, no done pulse.
      captured_data = 16'h1234;
      start         = 1'b1;
      sample_ready  = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check_sample("mid", 2, 3'd0);
      reset = 1'b0;
      tick();
      check_reset_vals("mid_rst");
      reset = 1'b1;
      tick();
      check_reset_vals("mid_after");
      start = 1'b1;
      tick();
      start = 1'b0;
      drain_frame("mid_new", {3'd1, 3'd1, 3'd0, 3'd6, 3'd4});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
